// File: rtl/color_matrix_pkg.sv
// Shared types, coefficient tables and helpers for the streaming colour-matrix block.
package color_matrix_pkg;

   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_SEPIA = 2'd1,
      MODE_GRAY  = 2'd2,
      MODE_NEG   = 2'd3
   } mode_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   localparam int unsigned BASE_FRAC = 10;

   // Reference coefficients in Q0.10, rows are output channels R,G,B
   localparam int unsigned SEPIA_Q10 [3][3] = '{
      '{402, 787, 194},
      '{357, 702, 172},
      '{279, 547, 134}
   };
   localparam int unsigned GRAY_Q10 [3] = '{306, 601, 117};

   // Coefficient for (output o, input i) rescaled to coef_w fraction bits
   function automatic int unsigned coef_val(input mode_t m, input logic [1:0] o,
                                            input logic [1:0] i, input int unsigned coef_w);
      int unsigned q10;
      q10 = 0;
      case (m)
         MODE_SEPIA: q10 = SEPIA_Q10[o][i];
         MODE_GRAY:  q10 = GRAY_Q10[i];
         default:    q10 = (o == i) ? (1 << BASE_FRAC) : 0;
      endcase
      if (coef_w >= BASE_FRAC)
         return q10 << (coef_w - BASE_FRAC);
      else
         return (q10 + (1 << (BASE_FRAC - coef_w - 1))) >> (BASE_FRAC - coef_w);
   endfunction

   function automatic int unsigned saturate(input int unsigned v, input int unsigned maxv);
      return (v > maxv) ? maxv : v;
   endfunction

endpackage

// File: rtl/color_matrix_mac.sv
// One output channel: three products, sum, shift and saturate, with a bypass for negative mode.
// COLOR_MATRIX_ROUND_EN selects round-half-up instead of truncation before the shift.
module color_matrix_mac
   import color_matrix_pkg::*;
#(
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned COEF_W = 10
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [3*PIX_W-1:0]        pix,
   input  logic [3*(COEF_W+1)-1:0]   coef,
   input  logic                      bypass,
   input  logic [PIX_W-1:0]          bypass_pix,
   output logic [PIX_W-1:0]          res
);

   localparam int unsigned CW       = COEF_W + 1;
   localparam int unsigned PROD_W   = PIX_W + CW;
   localparam int unsigned SUM_W    = PIX_W + COEF_W + 2;
   localparam int unsigned SHR_W    = SUM_W - COEF_W;
   localparam int unsigned PIX_MAX  = (1 << PIX_W) - 1;
`ifdef COLOR_MATRIX_ROUND_EN
   localparam logic [SUM_W-1:0] RND = SUM_W'(1) << (COEF_W - 1);
`else
   localparam logic [SUM_W-1:0] RND = '0;
`endif

   logic [PROD_W-1:0] prod [3];
   logic              bypass_q;
   logic [PIX_W-1:0]  bypass_pix_q;
   logic [SUM_W-1:0]  sum;
   logic [SHR_W-1:0]  shr;

   // Identity rows can reach 2^COEF_W, so the sum needs two guard bits
   always_comb begin
      sum = SUM_W'(prod[0]) + SUM_W'(prod[1]) + SUM_W'(prod[2]) + RND;
      shr = sum[SUM_W-1:COEF_W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 3; k++)
            prod[k] <= '0;
         bypass_q     <= 1'b0;
         bypass_pix_q <= '0;
         res          <= '0;
      end else if (en) begin
         for (int k = 0; k < 3; k++)
            prod[k] <= PROD_W'(pix[k*PIX_W +: PIX_W]) * PROD_W'(coef[k*CW +: CW]);
         bypass_q     <= bypass;
         bypass_pix_q <= bypass_pix;
         res          <= bypass_q ? bypass_pix_q : PIX_W'(saturate(32'(shr), PIX_MAX));
      end
   end

endmodule

// File: rtl/color_matrix_stream.sv
// Streaming per-pixel RGB colour transform with frame tracking and valid/ready backpressure.
// Rounding before the shift is enabled by defining COLOR_MATRIX_ROUND_EN.
module color_matrix_stream
   import color_matrix_pkg::*;
#(
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned COEF_W = 10,
   parameter int unsigned WIDTH  = 768,
   parameter int unsigned HEIGHT = 512
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           sel,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_sof,
   input  logic [3*PIX_W-1:0]   in_pix,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [3*PIX_W-1:0]   out_pix,
   output logic                 out_eol,
   output logic                 out_eof,
   output logic                 frame_err
);

   localparam int unsigned CW    = COEF_W + 1;
   localparam int unsigned COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   state_t             state;
   mode_t              mode;
   logic [COL_W-1:0]   col;
   logic [ROW_W-1:0]   row;

   logic               accept;
   logic               start;
   mode_t              cur_mode;
   logic [COL_W-1:0]   cur_col;
   logic [ROW_W-1:0]   cur_row;
   logic               last_col;
   logic               last_row;

   logic               s1_valid, s1_eol, s1_eof;
   logic [3*PIX_W-1:0] s1_pix;
   mode_t              s1_mode;
   logic               s2_valid, s2_eol, s2_eof;
   logic [3*CW-1:0]    coef_row [3];

   // The whole pipeline moves as one; a full output stage blocks everything behind it
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // A pixel starts a frame on in_sof, or implicitly when it arrives while idle
   always_comb begin
      start    = in_sof || (state == ST_IDLE);
      cur_mode = in_sof ? mode_t'(sel) : mode;
      cur_col  = start ? '0 : col;
      cur_row  = start ? '0 : row;
      last_col = (cur_col == COL_W'(WIDTH - 1));
      last_row = (cur_row == ROW_W'(HEIGHT - 1));
   end

   // Frame FSM, position counters, mode register and sticky error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         mode      <= MODE_PASS;
         col       <= '0;
         row       <= '0;
         frame_err <= 1'b0;
      end else if (accept) begin
         if (in_sof)
            mode <= mode_t'(sel);
         if ((in_sof && state == ST_ACTIVE) || (!in_sof && state == ST_IDLE))
            frame_err <= 1'b1;
         if (last_col) begin
            col <= '0;
            if (last_row) begin
               row   <= '0;
               state <= ST_IDLE;
            end else begin
               row   <= cur_row + ROW_W'(1);
               state <= ST_ACTIVE;
            end
         end else begin
            col   <= cur_col + COL_W'(1);
            row   <= cur_row;
            state <= ST_ACTIVE;
         end
      end
   end

   // Stage valids and frame tags travel alongside the arithmetic in the MACs
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_eol    <= 1'b0;
         s1_eof    <= 1'b0;
         s1_pix    <= '0;
         s1_mode   <= MODE_PASS;
         s2_valid  <= 1'b0;
         s2_eol    <= 1'b0;
         s2_eof    <= 1'b0;
         out_valid <= 1'b0;
         out_eol   <= 1'b0;
         out_eof   <= 1'b0;
      end else if (in_ready) begin
         s1_valid  <= accept;
         s1_eol    <= accept && last_col;
         s1_eof    <= accept && last_col && last_row;
         s1_pix    <= in_pix;
         s1_mode   <= cur_mode;
         s2_valid  <= s1_valid;
         s2_eol    <= s1_eol;
         s2_eof    <= s1_eof;
         out_valid <= s2_valid;
         out_eol   <= s2_eol;
         out_eof   <= s2_eof;
      end
   end

   // Coefficients packed {R,G,B} to line up with the pixel channels
   always_comb begin
      for (int o = 0; o < 3; o++) begin
         coef_row[o] = '0;
         for (int i = 0; i < 3; i++)
            coef_row[o][(2-i)*CW +: CW] = CW'(coef_val(s1_mode, 2'(o), 2'(i), COEF_W));
      end
   end

   for (genvar o = 0; o < 3; o++) begin : g_ch
      color_matrix_mac #(
         .PIX_W  (PIX_W),
         .COEF_W (COEF_W)
      ) u_mac (
         .clk        (clk),
         .rst        (rst),
         .en         (in_ready),
         .pix        (s1_pix),
         .coef       (coef_row[o]),
         .bypass     (s1_mode == MODE_NEG),
         .bypass_pix (~s1_pix[(2-o)*PIX_W +: PIX_W]),
         .res        (out_pix[(2-o)*PIX_W +: PIX_W])
      );
   end

endmodule

// File: tb/tb_color_matrix_stream.sv
// Scoreboard bench for color_matrix_stream on a 4x2 frame; follows COLOR_MATRIX_ROUND_EN.
module tb_color_matrix_stream;

   localparam int unsigned PIX_W  = 8;
   localparam int unsigned COEF_W = 10;
   localparam int unsigned WIDTH  = 4;
   localparam int unsigned HEIGHT = 2;

`ifdef COLOR_MATRIX_ROUND_EN
   localparam logic [23:0] SEPIA_EXP = {8'd81, 8'd73, 8'd57};
   localparam logic [23:0] GRAY_EXP  = {8'd62, 8'd62, 8'd62};
`else
   localparam logic [23:0] SEPIA_EXP = {8'd81, 8'd72, 8'd56};
   localparam logic [23:0] GRAY_EXP  = {8'd61, 8'd61, 8'd61};
`endif
   localparam logic [23:0] PIX_A = {8'd100, 8'd50, 8'd20};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  sel = 2'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_sof = 1'b0;
   logic [23:0] in_pix = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [23:0] out_pix;
   logic        out_eol;
   logic        out_eof;
   logic        frame_err;

   always #5 clk = ~clk;

   color_matrix_stream #(
      .PIX_W  (PIX_W),
      .COEF_W (COEF_W),
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sof    (in_sof),
      .in_pix    (in_pix),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pix   (out_pix),
      .out_eol   (out_eol),
      .out_eof   (out_eof),
      .frame_err (frame_err)
   );

   typedef struct {
      logic [23:0] pix;
      logic        eol;
      logic        eof;
   } exp_t;

   exp_t        sb [$];
   int          checks = 0;
   int          errors = 0;
   int          m_mode = 0;
   int          m_col = 0;
   int          m_row = 0;
   bit          m_active = 0;
   bit          m_err = 0;
   int          stall_left = 0;
   bit          held = 0;
   logic [25:0] held_val = '0;
   bit          accepted = 0;
   bit          cur_use_lit = 0;
   logic [23:0] cur_lit = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] model(input int m, input logic [23:0] p);
      int c [3][3];
      int ch [3];
      int acc;
      logic [23:0] r;
      ch[0] = int'(p[23:16]);
      ch[1] = int'(p[15:8]);
      ch[2] = int'(p[7:0]);
      if (m == 0) return p;
      if (m == 3) return ~p;
      if (m == 1) c = '{'{402, 787, 194}, '{357, 702, 172}, '{279, 547, 134}};
      else        c = '{'{306, 601, 117}, '{306, 601, 117}, '{306, 601, 117}};
      r = '0;
      for (int o = 0; o < 3; o++) begin
         acc = c[o][0] * ch[0] + c[o][1] * ch[1] + c[o][2] * ch[2];
`ifdef COLOR_MATRIX_ROUND_EN
         acc = acc + 512;
`endif
         acc = acc / 1024;
         if (acc > 255) acc = 255;
         r[(2-o)*8 +: 8] = 8'(acc);
      end
      return r;
   endfunction

   task automatic model_accept();
      exp_t e;
      if (in_sof) begin
         if (m_active) m_err = 1;
         m_mode = int'(sel);
         m_col  = 0;
         m_row  = 0;
      end else if (!m_active) begin
         m_err = 1;
         m_col = 0;
         m_row = 0;
      end
      e.pix = cur_use_lit ? cur_lit : model(m_mode, in_pix);
      e.eol = (m_col == WIDTH - 1);
      e.eof = e.eol && (m_row == HEIGHT - 1);
      sb.push_back(e);
      m_active = 1;
      if (e.eol) begin
         m_col = 0;
         if (m_row == HEIGHT - 1) begin
            m_row    = 0;
            m_active = 0;
         end else begin
            m_row++;
         end
      end else begin
         m_col++;
      end
   endtask

   // One clock: sample at the falling edge, then let the rising edge happen
   task automatic tick();
      exp_t e;
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      #1;
      accepted = 0;
      check_eq("frame_err", frame_err, m_err);
      if (out_valid && !out_ready) begin
         check_eq("stall_in_ready", in_ready, 0);
         if (held) check_eq("stall_hold", {out_eol, out_eof, out_pix}, held_val);
         held     = 1;
         held_val = {out_eol, out_eof, out_pix};
      end else begin
         held = 0;
      end
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check_eq("spurious_out", out_valid, 0);
         end else begin
            e = sb.pop_front();
            check_eq("out_pix", out_pix, e.pix);
            check_eq("out_eol", out_eol, e.eol);
            check_eq("out_eof", out_eof, e.eof);
         end
      end
      if (in_valid && in_ready) begin
         model_accept();
         accepted = 1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_pix(input bit sof, input logic [1:0] s, input logic [23:0] p,
                            input bit use_lit = 0, input logic [23:0] lit = '0);
      in_valid    = 1'b1;
      in_sof      = sof;
      sel         = s;
      in_pix      = p;
      cur_use_lit = use_lit;
      cur_lit     = lit;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (accepted) break;
      end
      if (!accepted) check_eq("accept_timeout", accepted, 1);
      in_valid    = 1'b0;
      in_sof      = 1'b0;
      cur_use_lit = 0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   function automatic logic [23:0] rnd_pix();
      return 24'($urandom);
   endfunction

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_out_pix", out_pix, 0);
      check_eq("rst_out_eol", out_eol, 0);
      check_eq("rst_out_eof", out_eof, 0);
      check_eq("rst_frame_err", frame_err, 0);
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      m_mode     = 0;
      m_active   = 0;
      m_err      = 0;
      m_col      = 0;
      m_row      = 0;
      held       = 0;
      stall_left = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      do_reset();

      // Sepia frame with known-answer and saturation pixels
      drive_pix(1, 2'd1, PIX_A, 1, SEPIA_EXP);
      drive_pix(0, 2'd1, 24'hFFFFFF, 1, {8'd255, 8'd255, 8'd239});
      for (int k = 0; k < 6; k++) drive_pix(0, 2'd1, rnd_pix());
      idle(3);

      // Grayscale frame, sel noise mid-frame must be ignored
      drive_pix(1, 2'd2, PIX_A, 1, GRAY_EXP);
      for (int k = 0; k < 7; k++) drive_pix(0, 2'($urandom), rnd_pix());
      idle(2);

      // Negative frame
      drive_pix(1, 2'd3, PIX_A, 1, {8'd155, 8'd205, 8'd235});
      for (int k = 0; k < 7; k++) drive_pix(0, 2'd3, rnd_pix());

      // Back-to-back passthrough frame, sel moves to 2 at pixel 4, stall at pixel 5
      drive_pix(1, 2'd0, rnd_pix());
      for (int k = 1; k < 4; k++) drive_pix(0, 2'd0, rnd_pix());
      drive_pix(0, 2'd2, PIX_A, 1, PIX_A);
      stall_left = 5;
      for (int k = 5; k < 8; k++) drive_pix(0, 2'd2, rnd_pix());
      // Next frame immediately after the last pixel: grayscale, no error
      drive_pix(1, 2'd2, PIX_A, 1, GRAY_EXP);
      for (int k = 1; k < 8; k++) drive_pix(0, 2'd0, rnd_pix());
      idle(5);
      check_eq("clean_err", frame_err, 0);

      // Mid-frame in_sof restarts the frame and latches the error
      drive_pix(1, 2'd1, rnd_pix());
      for (int k = 1; k < 5; k++) drive_pix(0, 2'd1, rnd_pix());
      drive_pix(1, 2'd3, PIX_A, 1, {8'd155, 8'd205, 8'd235});
      for (int k = 1; k < 8; k++) drive_pix(0, 2'd1, rnd_pix());
      idle(5);
      check_eq("err_sticky", frame_err, 1);

      // Reset with pixels in flight: nothing stale may come out afterwards
      drive_pix(1, 2'd2, rnd_pix());
      drive_pix(0, 2'd2, rnd_pix());
      drive_pix(0, 2'd2, rnd_pix());
      do_reset();
      idle(8);

      // Pixel without in_sof while idle: error, processed with mode 0
      drive_pix(0, 2'd1, PIX_A, 1, PIX_A);
      for (int k = 1; k < 8; k++) drive_pix(0, 2'd1, rnd_pix());
      idle(6);
      check_eq("idle_err", frame_err, 1);
      check_eq("drain_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
